// File: rtl/adventure_room_fsm.sv
// Purpose : room-navigation FSM for the adventure game; feeds sw to sword_fsm and resolves the Dragon's Den from v.
// Latency : a single-button rising edge moves the player on the same posedge it is sampled; room/sw/win/die are Moore outputs of the state register.
// Backpress: none; buttons are level inputs, edge-detected here; simultaneous rises are dropped. Optional move budget under `MOVE_LIMIT_EN`.
module adventure_room_fsm #(
   parameter int CNT_W      = 6,
   parameter int MOVE_LIMIT = 20
) (
   input  logic             clock,
   input  logic             R,
   input  logic             N,
   input  logic             S,
   input  logic             E,
   input  logic             W,
   input  logic             v,
   output logic             sw,
   output logic [2:0]       room,
   output logic             win,
   output logic             die,
   output logic [CNT_W-1:0] move_count
);

   // Room codes double as the externally visible room number.
   typedef enum logic [2:0] {
      CAVE   = 3'd0,
      TUNNEL = 3'd1,
      RIVER  = 3'd2,
      STASH  = 3'd3,
      DEN    = 3'd4,
      VAULT  = 3'd5,
      GRAVE  = 3'd6
   } state_t;

   // Bit positions of the buttons inside the packed {N,S,E,W} vector.
   localparam int N_B = 3;
   localparam int S_B = 2;
   localparam int E_B = 1;
   localparam int W_B = 0;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(MOVE_LIMIT);

`ifdef MOVE_LIMIT_EN
   localparam bit LIMIT_EN = 1'b1;
`else
   localparam bit LIMIT_EN = 1'b0;
`endif

   state_t           state_q, state_d;
   logic [3:0]       btn_q, btn_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [3:0]       btn_now;
   logic [3:0]       rise;
   logic             one_rise;
   logic             move_ok;
   logic             limit_hit;
   logic             limit_state;

   // Edge detection: a move needs exactly one freshly pressed button this cycle.
   always_comb begin
      btn_now  = {N, S, E, W};
      btn_d    = btn_now;
      rise     = btn_now & ~btn_q;
      one_rise = (rise != 4'd0) && ((rise & (rise - 4'd1)) == 4'd0);
   end

   // Next-state and move-accept decode; the budget check overrides any move in the live rooms.
   always_comb begin
      state_d     = state_q;
      move_ok     = 1'b0;
      limit_state = 1'b0;
      case (state_q)
         CAVE: begin
            limit_state = 1'b1;
            if (one_rise && rise[E_B]) begin
               state_d = TUNNEL;
               move_ok = 1'b1;
            end
         end
         TUNNEL: begin
            limit_state = 1'b1;
            if (one_rise && rise[W_B]) begin
               state_d = CAVE;
               move_ok = 1'b1;
            end else if (one_rise && rise[S_B]) begin
               state_d = RIVER;
               move_ok = 1'b1;
            end
         end
         RIVER: begin
            limit_state = 1'b1;
            if (one_rise && rise[N_B]) begin
               state_d = TUNNEL;
               move_ok = 1'b1;
            end else if (one_rise && rise[W_B]) begin
               state_d = STASH;
               move_ok = 1'b1;
            end else if (one_rise && rise[E_B]) begin
               state_d = DEN;
               move_ok = 1'b1;
            end
         end
         STASH: begin
            limit_state = 1'b1;
            if (one_rise && rise[E_B]) begin
               state_d = RIVER;
               move_ok = 1'b1;
            end
         end
         // The sword was latched by sword_fsm while in STASH, so v is stable here.
         DEN:     state_d = v ? VAULT : GRAVE;
         VAULT:   state_d = VAULT;
         GRAVE:   state_d = GRAVE;
         default: state_d = CAVE;
      endcase

      limit_hit = LIMIT_EN && limit_state && (cnt_q == LIMIT_C);
      if (limit_hit) begin
         state_d = GRAVE;
         move_ok = 1'b0;
      end
   end

   // Saturating move counter; the automatic DEN exit never sets move_ok.
   always_comb begin
      cnt_d = cnt_q;
      if (move_ok && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // State, button history and counter registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (R) begin
         state_q <= CAVE;
         btn_q   <= 4'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         btn_q   <= btn_d;
         cnt_q   <= cnt_d;
      end
   end

   // Moore outputs decoded from the state register only.
   always_comb begin
      sw         = (state_q == STASH);
      win        = (state_q == VAULT);
      die        = (state_q == GRAVE);
      room       = state_q;
      move_count = cnt_q;
   end

endmodule
